// File: rtl/axi_rd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_bridge_pkg
// Description : Shared CPU package: read-bridge FSM encoding, default AXI IDs
//               and the kseg0/kseg1 physical address mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] C_INST_ID   = 4'd0;
    localparam logic [3:0] C_DATA_ID   = 4'd1;
    localparam logic [2:0] C_SIZE_WORD = 3'b010;

    // kseg0 (0x8...) and kseg1 (0xA...) both alias the low 512 MB of physical space.
    function automatic logic [31:0] kseg_map(input logic [31:0] addr, input logic enable);
        logic [31:0] mapped;
        mapped = addr;
        if (enable && (addr[31:30] == 2'b10)) begin
            mapped[31:29] = 3'b000;
        end
        return mapped;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rd_arbiter
// Description : Fixed-priority (data over instruction) request selection and
//               addr_ok generation for the AXI read bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_arbiter (
    input  logic idle,
    input  logic inst_req,
    input  logic data_req,
    output logic inst_addr_ok,
    output logic data_addr_ok,
    output logic accept,
    output logic sel_data
);

    assign sel_data     = data_req;
    assign data_addr_ok = idle & data_req;
    assign inst_addr_ok = idle & inst_req & ~data_req;
    assign accept       = data_addr_ok | inst_addr_ok;

endmodule
`default_nettype wire

// File: rtl/axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_bridge
// Description : Instruction/data read port to single-beat AXI read bridge,
//               one transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_bridge
    import axi_rd_bridge_pkg::*;
#(
    parameter logic [3:0]  INST_ID  = C_INST_ID,
    parameter logic [3:0]  DATA_ID  = C_DATA_ID,
    parameter int unsigned MAP_KSEG = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_sel_data;
    logic        w_beat;
    logic        w_complete;
    logic        w_bad_id;
    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [2:0]  r_arsize;
    logic        r_is_data;
    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_rd_err;

    rd_arbiter u_arbiter (
        .idle         (r_state == ST_IDLE),
        .inst_req     (inst_req),
        .data_req     (data_req),
        .inst_addr_ok (inst_addr_ok),
        .data_addr_ok (data_addr_ok),
        .accept       (w_accept),
        .sel_data     (w_sel_data)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_next_state = ST_ADDR;
            ST_ADDR: if (arready)    w_next_state = ST_DATA;
            ST_DATA: if (w_complete) w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        case (r_state)
            ST_ADDR: arvalid = 1'b1;
            ST_DATA: rready  = 1'b1;
            default: ;
        endcase
    end

    // Beats are only consumed in DATA; an ID mismatch is dropped but flagged.
    assign w_beat     = rready & rvalid;
    assign w_complete = w_beat & rlast & (rid == r_arid);
    assign w_bad_id   = w_beat & (rid != r_arid);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_araddr       <= 32'd0;
            r_arid         <= 4'd0;
            r_arsize       <= C_SIZE_WORD;
            r_is_data      <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_inst_rdata   <= 32'd0;
            r_data_rdata   <= 32'd0;
            r_rd_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr  <= kseg_map(w_sel_data ? data_addr : inst_addr, MAP_KSEG != 0);
                r_arid    <= w_sel_data ? DATA_ID : INST_ID;
                r_arsize  <= w_sel_data ? data_size : C_SIZE_WORD;
                r_is_data <= w_sel_data;
            end
            r_inst_data_ok <= w_complete & ~r_is_data;
            r_data_data_ok <= w_complete & r_is_data;
            if (w_complete) begin
                if (r_is_data) begin
                    r_data_rdata <= rdata;
                end else begin
                    r_inst_rdata <= rdata;
                end
            end
            if (w_bad_id || (w_complete && (rresp != 2'b00))) begin
                r_rd_err <= 1'b1;
            end
        end
    end

    assign araddr       = r_araddr;
    assign arid         = r_arid;
    assign arsize       = r_arsize;
    assign arlen        = 4'd0;
    assign arburst      = 2'b01;
    assign arlock       = 2'b00;
    assign arcache      = 4'd0;
    assign arprot       = 3'd0;
    assign inst_data_ok = r_inst_data_ok;
    assign data_data_ok = r_data_data_ok;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;
    assign rd_err       = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_bridge
// Description : Directed self-checking bench for axi_rd_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_bridge;

    logic        aclk;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_err;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rd_bridge dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arlock       (arlock),
        .arcache      (arcache),
        .arprot       (arprot),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .rd_err       (rd_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic drive_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp);
        rvalid = 1'b1; rlast = 1'b1; rid = id; rdata = d; rresp = resp;
    endtask

    task automatic clear_beat();
        rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_addr = 32'd0; data_size = 3'd0;
        arready = 1'b1;
        clear_beat();
        repeat (2) @(negedge aclk);
        n_tests++;
        if ({arvalid, rready, inst_data_ok, data_data_ok, rd_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {arvalid, rready, inst_data_ok, data_data_ok, rd_err});
        end
        n_tests++;
        if ({araddr, arid, arsize} !== {32'd0, 4'd0, 3'b010}) begin
            n_fail++; $display("FAIL reset_ar: got araddr=%h arid=%0d arsize=%0d expected 0/0/2", araddr, arid, arsize);
        end
        n_tests++;
        if ({inst_rdata, data_rdata} !== 64'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({arlen, arburst, arlock, arcache, arprot} !== {4'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
            n_fail++; $display("FAIL ar_const: got len=%0d burst=%0d lock=%0d cache=%0d prot=%0d expected 0/1/0/0/0", arlen, arburst, arlock, arcache, arprot);
        end
    endtask

    task automatic test_inst_fetch();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; arready = 1'b1;
        #1;
        n_tests++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            n_fail++; $display("FAIL inst_addr_ok: got %b expected 10", {inst_addr_ok, data_addr_ok});
        end
        @(negedge aclk);
        inst_req = 1'b0;
        n_tests++;
        if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'h1FC0_0000, 4'd0, 3'd2}) begin
            n_fail++; $display("FAIL inst_ar: got v=%b addr=%h id=%0d size=%0d expected 1/1fc00000/0/2", arvalid, araddr, arid, arsize);
        end
        @(negedge aclk);
        n_tests++;
        if ({arvalid, rready} !== 2'b01) begin
            n_fail++; $display("FAIL inst_data_phase: got arvalid/rready=%b expected 01", {arvalid, rready});
        end
        drive_beat(4'd0, 32'h1234_5678, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h1234_5678}) begin
            n_fail++; $display("FAIL inst_data: got ok=%b rdata=%h expected 10/12345678", {inst_data_ok, data_data_ok}, inst_rdata);
        end
        @(negedge aclk);
        n_tests++;
        if ({inst_data_ok, inst_rdata, rd_err} !== {1'b0, 32'h1234_5678, 1'b0}) begin
            n_fail++; $display("FAIL inst_pulse_hold: got ok=%b rdata=%h err=%b expected 0/12345678/0", inst_data_ok, inst_rdata, rd_err);
        end
    endtask

    task automatic test_simultaneous();
        inst_req = 1'b1; inst_addr = 32'h8000_1000;
        data_req = 1'b1; data_addr = 32'h0000_3000; data_size = 3'd2;
        #1;
        n_tests++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
            n_fail++; $display("FAIL prio_addr_ok: got inst/data=%b expected 01", {inst_addr_ok, data_addr_ok});
        end
        @(negedge aclk);
        data_req = 1'b0;
        n_tests++;
        if ({arid, araddr, inst_addr_ok} !== {4'd1, 32'h0000_3000, 1'b0}) begin
            n_fail++; $display("FAIL prio_ar: got id=%0d addr=%h inst_ok=%b expected 1/00003000/0", arid, araddr, inst_addr_ok);
        end
        @(negedge aclk);
        n_tests++;
        if (inst_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL no_accept_in_data: got inst_addr_ok=%b expected 0", inst_addr_ok);
        end
        drive_beat(4'd1, 32'hDEAD_BEEF, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({data_data_ok, data_rdata, inst_addr_ok} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
            n_fail++; $display("FAIL prio_data_then_inst: got ok=%b rdata=%h inst_ok=%b expected 1/deadbeef/1", data_data_ok, data_rdata, inst_addr_ok);
        end
        @(negedge aclk);
        inst_req = 1'b0;
        n_tests++;
        if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h0000_1000, 3'd2}) begin
            n_fail++; $display("FAIL inst_after_data: got v=%b id=%0d addr=%h size=%0d expected 1/0/00001000/2", arvalid, arid, araddr, arsize);
        end
        @(negedge aclk);
        drive_beat(4'd0, 32'h0BAD_F00D, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({inst_data_ok, inst_rdata, data_rdata} !== {1'b1, 32'h0BAD_F00D, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL inst_second: got ok=%b irdata=%h drdata=%h expected 1/0badf00d/deadbeef", inst_data_ok, inst_rdata, data_rdata);
        end
        @(negedge aclk);
    endtask

    task automatic test_backpressure();
        data_req = 1'b1; data_addr = 32'hA000_0040; data_size = 3'd1; arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            data_req = 1'b0;
            n_tests++;
            if ({arvalid, rready, araddr, arsize} !== {2'b10, 32'h0000_0040, 3'd1}) begin
                n_fail++; $display("FAIL ar_stall_%0d: got v/rr=%b addr=%h size=%0d expected 10/00000040/1", i, {arvalid, rready}, araddr, arsize);
            end
        end
        arready = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({arvalid, rready} !== 2'b01) begin
            n_fail++; $display("FAIL ar_release: got arvalid/rready=%b expected 01", {arvalid, rready});
        end
        drive_beat(4'd1, 32'h0000_5A5A, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({data_data_ok, data_rdata} !== {1'b1, 32'h0000_5A5A}) begin
            n_fail++; $display("FAIL bp_data: got ok=%b rdata=%h expected 1/00005a5a", data_data_ok, data_rdata);
        end
        @(negedge aclk);
    endtask

    task automatic test_wrong_id();
        data_req = 1'b1; data_addr = 32'h0000_2000; data_size = 3'd2;
        @(negedge aclk);
        data_req = 1'b0;
        @(negedge aclk);
        drive_beat(4'd3, 32'hBBBB_BBBB, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({rd_err, rready, data_data_ok, inst_data_ok} !== 4'b1100) begin
            n_fail++; $display("FAIL wrong_id_drop: got err/rready/dok/iok=%b expected 1100", {rd_err, rready, data_data_ok, inst_data_ok});
        end
        drive_beat(4'd1, 32'h1111_2222, 2'b00);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({data_data_ok, data_rdata, rd_err} !== {1'b1, 32'h1111_2222, 1'b1}) begin
            n_fail++; $display("FAIL wrong_id_recover: got ok=%b rdata=%h err=%b expected 1/11112222/1", data_data_ok, data_rdata, rd_err);
        end
        @(negedge aclk);
    endtask

    task automatic test_mid_reset();
        data_req = 1'b1; data_addr = 32'h0000_4000; data_size = 3'd2;
        @(negedge aclk);
        data_req = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        n_tests++;
        if ({arvalid, rready, rd_err, data_rdata} !== {3'b000, 32'd0}) begin
            n_fail++; $display("FAIL async_reset: got v/rr/err=%b rdata=%h expected 000/0", {arvalid, rready, rd_err}, data_rdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        drive_beat(4'd1, 32'h7777_7777, 2'b00);
        repeat (2) begin
            @(negedge aclk);
            n_tests++;
            if ({data_data_ok, inst_data_ok, arvalid, rready, data_rdata} !== {4'b0000, 32'd0}) begin
                n_fail++; $display("FAIL late_beat: got dok/iok/v/rr=%b rdata=%h expected 0000/0", {data_data_ok, inst_data_ok, arvalid, rready}, data_rdata);
            end
        end
        clear_beat();
        @(negedge aclk);
    endtask

    task automatic test_error_resp();
        data_req = 1'b1; data_addr = 32'h0000_1000; data_size = 3'd0;
        @(negedge aclk);
        data_req = 1'b0;
        n_tests++;
        if ({araddr, arsize, arid, rd_err} !== {32'h0000_1000, 3'd0, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL err_ar: got addr=%h size=%0d id=%0d err=%b expected 00001000/0/1/0", araddr, arsize, arid, rd_err);
        end
        @(negedge aclk);
        drive_beat(4'd1, 32'hCAFE_F00D, 2'b10);
        @(negedge aclk);
        clear_beat();
        n_tests++;
        if ({data_data_ok, data_rdata, rd_err} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin
            n_fail++; $display("FAIL err_resp: got ok=%b rdata=%h err=%b expected 1/cafef00d/1", data_data_ok, data_rdata, rd_err);
        end
        repeat (2) @(negedge aclk);
        n_tests++;
        if ({rd_err, data_data_ok} !== 2'b10) begin
            n_fail++; $display("FAIL err_sticky: got err/ok=%b expected 10", {rd_err, data_data_ok});
        end
    endtask

    initial begin
        test_reset();
        test_inst_fetch();
        test_simultaneous();
        test_backpressure();
        test_wrong_id();
        test_mid_reset();
        test_error_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
